serial_parallel_rx: RTL and testbench
=====================================

SERIAL_PARALLEL_RX -- requirements
Module: serial_parallel_rx

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, the alignment/idle byte.
REQ-002 SHALL have parameter LOCK_CNT, default 4, the number of consecutive aligned COMMA bytes required to go active (legal range 1..15).
REQ-003 SHALL have port clk_32f, input, 1, the single bit-rate clock; all state SHALL update only on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port data_in, input, 1, serial bit stream, MSB of each byte first.
REQ-006 SHALL have port data_rx000, output, 8, recovered byte feeding the downstream demux.
REQ-007 SHALL have port valid_rx000, output, 1, high when data_rx000 holds a non-COMMA payload byte.
REQ-008 SHALL have port active, output, 1, high once byte lock is achieved.

Function
REQ-009 SHALL maintain an 8-bit shift register sr; each edge, next_sr = {sr[6:0], data_in}, sr <= next_sr.
REQ-010 SHALL implement states SEARCH, LOCKING and ACTIVE, a 3-bit bit counter bit_cnt and a 4-bit comma counter bc_cnt.
REQ-011 In SEARCH, the block SHALL compare next_sr with COMMA every cycle (sliding, any bit offset); on match: bit_cnt <= 0, bc_cnt <= 1, and state <= LOCKING, or state <= ACTIVE with active <= 1 when LOCK_CNT == 1.
REQ-012 Outside SEARCH, bit_cnt SHALL increment every cycle and wrap 7 -> 0; a byte boundary is an edge where bit_cnt == 7 (8th bit after the last boundary or after comma detection).
REQ-013 In LOCKING, at a boundary with next_sr == COMMA, bc_cnt SHALL increment; when the incremented value equals LOCK_CNT, state <= ACTIVE and active <= 1 on that same edge.
REQ-014 In LOCKING, at a boundary with next_sr != COMMA, state SHALL return to SEARCH and bc_cnt SHALL clear; no comparison is made on non-boundary cycles in LOCKING.
REQ-015 In SEARCH and LOCKING, data_rx000 and valid_rx000 SHALL be 0, and the COMMA bytes consumed for lock SHALL NOT be presented.
REQ-016 In ACTIVE, at each boundary the block SHALL register data_rx000 <= next_sr and valid_rx000 <= (next_sr != COMMA); both SHALL hold for the following 8 cycles until the next boundary.
REQ-017 Latency: data_rx000 SHALL reflect a byte on the same edge that samples its LSB, with no extra pipeline stage.
REQ-018 ACTIVE SHALL be left only by reset; payload that matches no COMMA pattern SHALL NOT cause loss of lock.
REQ-019 A COMMA appearing at a non-boundary offset while in ACTIVE SHALL be ignored, and no realignment SHALL occur.

Reset
REQ-020 While reset is high at an edge: sr, bit_cnt and bc_cnt SHALL be 0; state SHALL be SEARCH; data_rx000 = 8'h00, valid_rx000 = 0 and active = 0, overriding data_in.
REQ-021 Reset asserted in any state, including mid-byte in ACTIVE, SHALL take effect at the next edge, and lock SHALL be reacquired from SEARCH afterwards.

Verification
REQ-022 The bench SHALL cover: reset, then 4x 0xBC serial with bit 0 aligned -> active rises on the edge sampling bit 32; data_rx000 = 0 and valid_rx000 = 0 throughout.
REQ-023 The bench SHALL cover: locked, then 0x55, 0xA3 -> data_rx000 = 0x55 with valid_rx000 = 1 for 8 cycles starting at the byte's 8th bit, then 0xA3 with valid_rx000 = 1.
REQ-024 The bench SHALL cover: locked, then 0xBC -> data_rx000 = 0xBC and valid_rx000 = 0 for 8 cycles; active stays 1.
REQ-025 The bench SHALL cover: reset, 3 bits 1,0,1, then 4x 0xBC -> lock at bit offset 3; active rises 35 cycles after reset release; the next payload 0x0F is output correctly.
REQ-026 The bench SHALL cover: reset, 0xBC, 0xBC, 0x00, then 4x 0xBC -> the sequence returns to SEARCH at the 0x00 boundary with active = 0, then locks after the second 4x 0xBC.
REQ-027 The bench SHALL cover: reset pulsed for 1 cycle mid-payload in ACTIVE -> on the next edge active = 0, valid_rx000 = 0 and data_rx000 = 0x00; relock requires 4 fresh COMMA bytes.

Source files
------------

// File: rtl/serial_parallel_rx.sv
// rtl/serial_parallel_rx.sv - serial byte receiver with comma alignment and lock
// Slides a COMMA search over the bit stream, confirms LOCK_CNT aligned commas, then emits bytes.
module serial_parallel_rx #(
   parameter logic [7:0]  COMMA    = 8'hBC,
   parameter int unsigned LOCK_CNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_rx000,
   output logic       valid_rx000,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

   state_t      state, state_n;
   logic [7:0]  sr;
   logic [7:0]  next_sr;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [3:0]  bc_cnt, bc_cnt_n;
   logic [3:0]  bc_inc;
   logic [7:0]  data_n;
   logic        valid_n;
   logic        active_n;
   logic        boundary;
   logic        is_comma;

   // The byte under test includes the bit arriving this edge, so output has no extra stage.
   assign next_sr  = {sr[6:0], data_in};
   assign is_comma = (next_sr == COMMA);
   assign boundary = (bit_cnt == 3'd7);
   assign bc_inc   = bc_cnt + 4'd1;

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state       <= SEARCH;
         sr          <= 8'h00;
         bit_cnt     <= 3'd0;
         bc_cnt      <= 4'd0;
         data_rx000  <= 8'h00;
         valid_rx000 <= 1'b0;
         active      <= 1'b0;
      end else begin
         state       <= state_n;
         sr          <= next_sr;
         bit_cnt     <= bit_cnt_n;
         bc_cnt      <= bc_cnt_n;
         data_rx000  <= data_n;
         valid_rx000 <= valid_n;
         active      <= active_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      bc_cnt_n  = bc_cnt;
      data_n    = data_rx000;
      valid_n   = valid_rx000;
      active_n  = active;

      case (state)
         SEARCH: begin
            data_n   = 8'h00;
            valid_n  = 1'b0;
            active_n = 1'b0;
            if (is_comma) begin
               bit_cnt_n = 3'd0;
               bc_cnt_n  = 4'd1;
               if (LOCK_TARGET == 4'd1) begin
                  state_n  = ACTIVE;
                  active_n = 1'b1;
               end else begin
                  state_n = LOCKING;
               end
            end
         end

         LOCKING: begin
            bit_cnt_n = bit_cnt + 3'd1;
            data_n    = 8'h00;
            valid_n   = 1'b0;
            active_n  = 1'b0;
            // Only boundary-aligned bytes count; a bad byte restarts the sliding search.
            if (boundary) begin
               if (is_comma) begin
                  bc_cnt_n = bc_inc;
                  if (bc_inc == LOCK_TARGET) begin
                     state_n  = ACTIVE;
                     active_n = 1'b1;
                  end
               end else begin
                  state_n  = SEARCH;
                  bc_cnt_n = 4'd0;
               end
            end
         end

         ACTIVE: begin
            bit_cnt_n = bit_cnt + 3'd1;
            active_n  = 1'b1;
            // Lock is sticky: off-boundary commas and any payload are passed through untouched.
            if (boundary) begin
               data_n  = next_sr;
               valid_n = !is_comma;
            end
         end

         default: begin
            state_n = SEARCH;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_parallel_rx.sv
// tb/tb_serial_parallel_rx.sv - scoreboard bench for serial_parallel_rx
// Driver queues the expected output triple per edge; a monitor pops and compares after each edge.
module tb_serial_parallel_rx;

   localparam logic [7:0] COMMA = 8'hBC;
   localparam int HOLD = 0;
   localparam int LOCK = 1;
   localparam int DATA = 2;
   localparam int IDLE = 3;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic       data_in = 1'b0;
   logic [7:0] data_rx000;
   logic       valid_rx000;
   logic       active;

   serial_parallel_rx #(.COMMA(COMMA), .LOCK_CNT(4)) dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_rx000  (data_rx000),
      .valid_rx000 (valid_rx000),
      .active      (active)
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      logic       a;
      logic       v;
      logic [7:0] d;
      int         step;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         step     = 0;
   logic       exp_a    = 1'b0;
   logic       exp_v    = 1'b0;
   logic [7:0] exp_d    = 8'h00;

   task automatic push_cycle(input logic r, input logic b);
      exp_t e;
      @(negedge clk_32f);
      reset   = r;
      data_in = b;
      step++;
      e.a    = exp_a;
      e.v    = exp_v;
      e.d    = exp_d;
      e.step = step;
      sb.push_back(e);
   endtask

   task automatic do_reset(input int n);
      logic rb;
      exp_a = 1'b0;
      exp_v = 1'b0;
      exp_d = 8'h00;
      for (int k = 0; k < n; k++) begin
         rb = 1'($urandom_range(1, 0));
         push_cycle(1'b1, rb);
      end
   endtask

   // mode decides what the edge sampling the LSB must show; other edges hold the previous outputs.
   task automatic send_byte(input logic [7:0] b, input int mode);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) begin
            if (mode == LOCK) begin
               exp_a = 1'b1;
            end else if (mode == DATA) begin
               exp_d = b;
               exp_v = 1'b1;
            end else if (mode == IDLE) begin
               exp_d = b;
               exp_v = 1'b0;
            end
         end
         push_cycle(1'b0, b[i]);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_32f);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (active !== e.a) begin
               n_fail++;
               $display("FAIL active step %0d: got %b expected %b", e.step, active, e.a);
            end
            n_checks++;
            if (valid_rx000 !== e.v) begin
               n_fail++;
               $display("FAIL valid_rx000 step %0d: got %b expected %b", e.step, valid_rx000, e.v);
            end
            n_checks++;
            if (data_rx000 !== e.d) begin
               n_fail++;
               $display("FAIL data_rx000 step %0d: got %02h expected %02h", e.step, data_rx000, e.d);
            end
         end
      end
   end

   initial begin : driver
      int waits;

      // Aligned lock: active rises on the 32nd bit after reset release.
      do_reset(3);
      repeat (3) send_byte(COMMA, HOLD);
      send_byte(COMMA, LOCK);
      send_byte(8'h55, DATA);
      send_byte(8'hA3, DATA);
      send_byte(COMMA, IDLE);
      // 0x0B,0xC0 hides a comma at offset 4; it must not realign.
      send_byte(8'h0B, DATA);
      send_byte(8'hC0, DATA);
      send_byte(8'h7E, DATA);

      // Lock at bit offset 3: active at edge 35 after release.
      do_reset(2);
      push_cycle(1'b0, 1'b1);
      push_cycle(1'b0, 1'b0);
      push_cycle(1'b0, 1'b1);
      repeat (3) send_byte(COMMA, HOLD);
      send_byte(COMMA, LOCK);
      send_byte(8'h0F, DATA);

      // Broken lock sequence drops back to search, then relocks on four fresh commas.
      do_reset(2);
      send_byte(COMMA, HOLD);
      send_byte(COMMA, HOLD);
      send_byte(8'h00, HOLD);
      repeat (3) send_byte(COMMA, HOLD);
      send_byte(COMMA, LOCK);
      send_byte(8'h96, DATA);

      // One-cycle reset mid-payload clears everything on the next edge.
      send_byte(8'h3C, DATA);
      push_cycle(1'b0, 1'b1);
      push_cycle(1'b0, 1'b1);
      push_cycle(1'b0, 1'b0);
      do_reset(1);
      repeat (3) send_byte(COMMA, HOLD);
      send_byte(COMMA, LOCK);
      send_byte(8'hE1, DATA);
      send_byte(COMMA, IDLE);

      waits = 0;
      while (sb.size() > 0 && waits < 20) begin
         @(posedge clk_32f);
         #2;
         waits++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
